sha256_msg_schedule: RTL

- Downstream neighbour of the SHA-256 message builder in the hash datapath.
- Accepts padded 512-bit message blocks and expands each one into the 64-word SHA-256 message schedule W[0..63].
- Emits one 32-bit word per cycle, with index and last flags, to the compression stage.
- Valid/ready handshakes on both sides, matching the rest of the datapath.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_msg_schedule.sv | 100 ++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and small-sigma helpers used by the schedule and
// compression stages of the hash datapath.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_WORDS   = 64;
  localparam int SHA256_WIN     = 16;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_RUN
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0_small(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1_small(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one padded 512-bit block into W[0..NUM_WORDS-1]
// using a 16-word sliding window, one word per output handshake.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      sync_rst,
  input  logic [SHA256_BLOCK_W-1:0] data_in,
  input  logic                      data_in_last,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic [31:0]               data_out,
  output logic [5:0]                data_out_index,
  output logic                      data_out_block_last,
  output logic                      data_out_last,
  output logic                      data_out_valid,
  input  logic                      data_out_ready
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  sched_state_t state, state_next;
  word_t        win [SHA256_WIN];
  logic [5:0]   t;
  logic         msg_last_reg;

  logic  load, shift;
  word_t next_word;

  assign next_word = sigma1_small(win[14]) + win[9] + sigma0_small(win[1]) + win[0];

  // en is folded into the handshake terms, so a frozen block never advances.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_next     = state;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    case (state)
      SCHED_IDLE: begin
        data_in_ready = en;
        if (en && data_in_valid) begin
          load       = 1'b1;
          state_next = SCHED_RUN;
        end
      end
      SCHED_RUN: begin
        data_out_valid = en;
        if (en && data_out_ready) begin
          if (t == LAST_IDX) state_next = SCHED_IDLE;
          else               shift      = 1'b1;
        end
      end
      default: state_next = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!nrst)         state <= SCHED_IDLE;
    else if (sync_rst) state <= SCHED_IDLE;
    else               state <= state_next;
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: the window is deliberately reset so data_out reads 0 after reset and
    // no stale word from an aborted block can ever appear on the output.
    if (!nrst) begin
      for (int k = 0; k < SHA256_WIN; k++) win[k] <= '0;
      t            <= '0;
      msg_last_reg <= 1'b0;
    end else if (sync_rst) begin
      for (int k = 0; k < SHA256_WIN; k++) win[k] <= '0;
      t            <= '0;
      msg_last_reg <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < SHA256_WIN; k++)
        win[k] <= data_in[SHA256_BLOCK_W-1-32*k -: 32];
      t            <= '0;
      msg_last_reg <= data_in_last;
    end else if (shift) begin
      for (int k = 0; k < SHA256_WIN - 1; k++) win[k] <= win[k+1];
      win[SHA256_WIN-1] <= next_word;
      t                 <= t + 6'd1;
    end
  end

  assign data_out            = win[0];
  assign data_out_index      = t;
  assign data_out_block_last = (t == LAST_IDX) && data_out_valid;
  assign data_out_last       = data_out_block_last && msg_last_reg;

endmodule
